// File: rtl/arith_multicycle.sv
// arith_multicycle
//   Multi-cycle MIPS arithmetic machine. It fetches one 32-bit instruction
//   over a stallable request/valid handshake and executes it in a second
//   cycle. Results go into a 32 x WIDTH register file.
//
//   Fetch handshake: imem_req is high for every cycle spent in FETCH. The
//   instruction is taken on the rising edge where imem_req and imem_valid are
//   both high. The memory may hold imem_valid low for any number of cycles,
//   and the machine waits with PC stable. imem_valid carries no meaning while
//   imem_req is low.
//
//   An unrecognised instruction sets a sticky exception and parks the machine
//   in HALT. Only reset leaves HALT.
//
// Parameters
//   WIDTH        datapath and register width, 16..64
//   PC_RESET     word-aligned PC loaded on reset
//   RETIRE_BITS  width of the retired-instruction counter
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-high reset
//   imem_req    fetch request (high exactly in FETCH)
//   imem_addr   word address PC[31:2]
//   imem_data   instruction word
//   imem_valid  imem_data is valid for imem_addr this cycle
//   except      sticky illegal-instruction flag
//   retired     count of executed instructions (wraps)
//   dbg_addr    debug register select
//   dbg_data    combinational read of register dbg_addr (r0 reads 0)
module arith_multicycle #(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] PC_RESET    = 32'h0,
    parameter int          RETIRE_BITS = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [29:0]            imem_addr,
    input  logic [31:0]            imem_data,
    input  logic                   imem_valid,
    output logic                   except,
    output logic [RETIRE_BITS-1:0] retired,
    input  logic [4:0]             dbg_addr,
    output logic [WIDTH-1:0]       dbg_data
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    // PC is held as a word address. Incrementing it by one is PC+4 mod 2^32.
    logic [29:0]            pc_q;
    logic [31:0]            ir_q;
    logic                   except_q;
    logic [RETIRE_BITS-1:0] retired_q;
    logic [WIDTH-1:0]       rf_q [32];

    // FSM control strobes
    logic ir_load;
    logic do_retire;
    logic do_fault;

    // Decode and execute
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       rs, rt, rd;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] imm_sext, imm_zext;
    logic [WIDTH-1:0] result;
    logic [4:0]       wr_addr;
    logic             legal;
    logic             unused_shamt;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];
    assign unused_shamt = ^ir_q[10:6];

    // Both operands are read before the writeback edge, so an instruction
    // that names the same register as source and destination sees the old value.
    assign op_a = rf_q[rs];
    assign op_b = rf_q[rt];

    // A size cast of a signed value sign-extends. This also works at WIDTH=16.
    assign imm_sext = WIDTH'($signed(ir_q[15:0]));
    assign imm_zext = WIDTH'(ir_q[15:0]);

    always_comb begin
        legal   = 1'b1;
        wr_addr = rd;
        result  = '0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20:   result = op_a + op_b;
                    6'h22:   result = op_a - op_b;
                    6'h24:   result = op_a & op_b;
                    6'h25:   result = op_a | op_b;
                    6'h26:   result = op_a ^ op_b;
                    6'h27:   result = ~(op_a | op_b);
                    default: legal  = 1'b0;
                endcase
            end
            6'h08: begin
                wr_addr = rt;
                result  = op_a + imm_sext;
            end
            6'h0c: begin
                wr_addr = rt;
                result  = op_a & imm_zext;
            end
            6'h0d: begin
                wr_addr = rt;
                result  = op_a | imm_zext;
            end
            6'h0e: begin
                wr_addr = rt;
                result  = op_a ^ imm_zext;
            end
            default: legal = 1'b0;
        endcase
    end

    // Next-state logic and outputs
    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        do_retire = 1'b0;
        do_fault  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_load = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (legal) begin
                    do_retire = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    do_fault = 1'b1;
                    state_d  = ST_HALT;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= PC_RESET[31:2];
            ir_q      <= '0;
            except_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (ir_load) begin
                ir_q <= imem_data;
            end
            if (do_retire) begin
                pc_q      <= pc_q + 30'd1;
                retired_q <= retired_q + RETIRE_BITS'(1);
            end
            if (do_fault) begin
                except_q <= 1'b1;
            end
        end
    end

    // Register file. r0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (do_retire && (wr_addr != 5'd0)) begin
            rf_q[wr_addr] <= result;
        end
    end

    assign imem_addr = pc_q;
    assign except    = except_q;
    assign retired   = retired_q;
    assign dbg_data  = (dbg_addr == 5'd0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_arith_multicycle.sv
// Bench for arith_multicycle. A 32-bit and a 16-bit instance run the same
// program side by side. The expected retirement stream comes from a
// reference interpreter over the program image.
module tb_arith_multicycle;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_valid;
    logic [4:0]  dbg_addr;

    logic        imem_req,   imem_req_h;
    logic [29:0] imem_addr,  imem_addr_h;
    logic [31:0] imem_data,  imem_data_h;
    logic        except,     except_h;
    logic [15:0] retired,    retired_h;
    logic [31:0] dbg_data;
    logic [15:0] dbg_data_h;

    logic [31:0] prog [256];

    assign imem_data   = prog[imem_addr[7:0]];
    assign imem_data_h = prog[imem_addr_h[7:0]];

    arith_multicycle #(.WIDTH(32), .PC_RESET(32'h0), .RETIRE_BITS(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .except     (except),
        .retired    (retired),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    arith_multicycle #(.WIDTH(16), .PC_RESET(32'h0), .RETIRE_BITS(16)) dut_h (
        .clock      (clock),
        .reset      (reset),
        .imem_req   (imem_req_h),
        .imem_addr  (imem_addr_h),
        .imem_data  (imem_data_h),
        .imem_valid (imem_valid),
        .except     (except_h),
        .retired    (retired_h),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data_h)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] val;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] mregs [32];
    int          n_legal;
    int          halt_idx;

    function automatic void model_step(input logic [31:0] ins, output logic ok,
                                       output logic [4:0] dst, output logic [31:0] val);
        logic [31:0] a, b, sx, zx;
        a   = mregs[ins[25:21]];
        b   = mregs[ins[20:16]];
        sx  = {{16{ins[15]}}, ins[15:0]};
        zx  = {16'h0, ins[15:0]};
        ok  = 1'b1;
        dst = ins[20:16];
        val = 32'h0;
        case (ins[31:26])
            6'h00: begin
                dst = ins[15:11];
                case (ins[5:0])
                    6'h20:   val = a + b;
                    6'h22:   val = a - b;
                    6'h24:   val = a & b;
                    6'h25:   val = a | b;
                    6'h26:   val = a ^ b;
                    6'h27:   val = ~(a | b);
                    default: ok = 1'b0;
                endcase
            end
            6'h08:   val = a + sx;
            6'h0c:   val = a & zx;
            6'h0d:   val = a | zx;
            6'h0e:   val = a ^ zx;
            default: ok = 1'b0;
        endcase
    endfunction

    // Random destinations avoid r1..r7 so the directed results survive to the end.
    function automatic logic [4:0] rand_dest();
        int d;
        d = $urandom_range(0, 24);
        return (d == 0) ? 5'd0 : 5'(d + 7);
    endfunction

    task automatic build_program();
        logic [31:0] dir [6];
        logic [5:0]  functs [6];
        logic [5:0]  iops [4];
        logic        ok;
        logic [4:0]  dst;
        logic [31:0] val;
        int          k;
        dir    = '{32'h20010005, 32'h2002FFFF, 32'h3043FFFF,
                   32'h00232022, 32'h00002827, 32'h20000007};
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
        iops   = '{6'h08, 6'h0c, 6'h0d, 6'h0e};
        for (int i = 0; i < 256; i++) prog[i] = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) prog[i] = dir[i];
        for (int i = 6; i < 156; i++) begin
            k = $urandom_range(0, 9);
            if (k < 6)
                prog[i] = {6'h00, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                           rand_dest(), 5'($urandom_range(0, 31)), functs[k]};
            else
                prog[i] = {iops[k-6], 5'($urandom_range(0, 31)), rand_dest(),
                           16'($urandom)};
        end
        prog[156] = 32'h8C000000;

        for (int r = 0; r < 32; r++) mregs[r] = 32'h0;
        n_legal  = 0;
        halt_idx = -1;
        for (int i = 0; i < 256; i++) begin
            model_step(prog[i], ok, dst, val);
            if (!ok) begin
                halt_idx = i;
                break;
            end
            if (dst != 5'd0) mregs[dst] = val;
            exp_q.push_back('{dest: dst, val: (dst == 5'd0) ? 32'h0 : val, pc: 32'((i + 1) * 4)});
            n_legal++;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [15:0] last_ret = 16'h0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                last_ret = 16'h0;
            end else if (retired != last_ret) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", retired, last_ret);
                end else begin
                    e = exp_q.pop_front();
                    dbg_addr = e.dest;
                    #1;
                    check("retire_count", retired,   last_ret + 16'd1);
                    check("retire_count_h", retired_h, last_ret + 16'd1);
                    check("wb_value",     dbg_data,  e.val);
                    check("wb_value_h",   dbg_data_h, e.val[15:0]);
                    check("pc_after",     imem_addr, e.pc[31:2]);
                    check("pc_after_h",   imem_addr_h, e.pc[31:2]);
                end
                last_ret = retired;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int          cycles;
        logic [31:0] spec_vals [6];
        spec_vals = '{32'h0, 32'h5, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0006, 32'hFFFF_FFFF};

        reset      = 1'b1;
        imem_valid = 1'b0;
        dbg_addr   = 5'd0;
        build_program();

        // Reset values
        repeat (2) @(negedge clock);
        check("reset_req",     imem_req,  1'b1);
        check("reset_addr",    imem_addr, 30'h0);
        check("reset_except",  except,    1'b0);
        check("reset_retired", retired,   16'h0);
        check("reset_req_h",   imem_req_h, 1'b1);
        for (int r = 0; r < 32; r++) begin
            dbg_addr = 5'(r);
            #1;
            check("reset_reg",   dbg_data,   32'h0);
            check("reset_reg_h", dbg_data_h, 16'h0);
        end
        @(negedge clock);
        reset = 1'b0;

        // Memory wait: 3 cycles with imem_valid low
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_req",     imem_req,  1'b1);
            check("stall_addr",    imem_addr, 30'h0);
            check("stall_retired", retired,   16'h0);
        end

        // Zero-wait first instruction: retires after the second edge
        imem_valid = 1'b1;
        @(posedge clock);
        #1;
        check("exec_req",       imem_req, 1'b0);
        check("exec_retired",   retired,  16'h0);
        @(posedge clock);
        #1;
        check("first_retired", retired,   16'h1);
        check("first_pc",      imem_addr, 30'h1);
        check("first_except",  except,    1'b0);

        // Random memory latency until the illegal word halts the machine
        cycles = 0;
        while (!except && cycles < 5000) begin
            @(negedge clock);
            imem_valid = ($urandom_range(0, 3) != 0);
            cycles++;
        end
        check("halt_reached", except, 1'b1);
        @(negedge clock);
        check("halt_req",     imem_req,    1'b0);
        check("halt_pc",      imem_addr,   30'(halt_idx));
        check("halt_retired", retired,     16'(n_legal));
        check("halt_except_h", except_h,   1'b1);
        check("halt_pc_h",    imem_addr_h, 30'(halt_idx));
        check("queue_drained", exp_q.size(), 0);

        // Valid pulses while halted are ignored
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            imem_valid = i[0];
        end
        @(negedge clock);
        imem_valid = 1'b0;
        check("frozen_req",     imem_req,  1'b0);
        check("frozen_pc",      imem_addr, 30'(halt_idx));
        check("frozen_retired", retired,   16'(n_legal));
        check("frozen_except",  except,    1'b1);

        // Register file against the model and the directed results
        for (int r = 0; r < 32; r++) begin
            dbg_addr = 5'(r);
            #1;
            check("final_reg",   dbg_data,   mregs[r]);
            check("final_reg_h", dbg_data_h, mregs[r][15:0]);
        end
        for (int r = 0; r < 6; r++) begin
            dbg_addr = 5'(r);
            #1;
            check("directed_reg", dbg_data, spec_vals[r]);
        end
        dbg_addr = 5'd2;
        #1;
        check("directed_r2_h", dbg_data_h, 16'hFFFF);

        // Reset clears the sticky exception
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("clr_except",  except,    1'b0);
        check("clr_retired", retired,   16'h0);
        check("clr_req",     imem_req,  1'b1);
        check("clr_addr",    imem_addr, 30'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset asserted asynchronously during EXEC of addi $6,$0,9
        prog[0] = 32'h20060009;
        dbg_addr = 5'd6;
        @(negedge clock);
        imem_valid = 1'b1;
        @(posedge clock);
        #2;
        check("midexec_req", imem_req, 1'b0);
        reset = 1'b1;
        #1;
        check("async_req",     imem_req,   1'b1);
        check("async_addr",    imem_addr,  30'h0);
        check("async_except",  except,     1'b0);
        check("async_retired", retired,    16'h0);
        check("async_r6",      dbg_data,   32'h0);
        check("async_r6_h",    dbg_data_h, 16'h0);
        imem_valid = 1'b0;
        @(posedge clock);
        #1;
        check("async_r6_after_edge", dbg_data, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("idle_retired", retired, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
